// File: rtl/sanmoku_pkg.sv
// Shared types and constants for the sanmoku match controller.
// Move codes, command width and controller state encoding.
package sanmoku_pkg;

  localparam int CMD_W = 4;

  localparam logic [CMD_W-1:0] FIRST  = 4'd0;
  localparam logic [CMD_W-1:0] SECOND = 4'd2;
  localparam logic [CMD_W-1:0] THIRD  = 4'd1;
  localparam logic [CMD_W-1:0] FOURTH = 4'd3;

  typedef enum logic [2:0] {
    IDLE,
    ERST,
    WAIT_MOVE,
    STEP,
    CHECK,
    SCORE,
    DONE
  } ctrl_state_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/sanmoku_move_timer.sv
// Move timer: counts cycles waiting for a player move.
// Cleared by clr, flags expire on its TIMEOUT-th counted cycle.
module sanmoku_move_timer
  import sanmoku_pkg::*;
#(
  parameter int TIMEOUT = 1000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT) + 1;

  logic [W-1:0] cnt;

  assign expire = (cnt == W'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sanmoku_match_ctrl.sv
// Best-of-GAMES match sequencer around the sanmoku engine.
// Handles engine reset, move handshake, timeout default and scoring.
module sanmoku_match_ctrl
  import sanmoku_pkg::*;
#(
  parameter int GAMES          = 3,
  parameter int TIMEOUT        = 1000,
  parameter int DEFAULT_CMD    = 0,
  parameter int ENG_RST_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             mv_valid,
  input  logic [CMD_W-1:0] mv_cmd,
  output logic             mv_ready,
  output logic             mv_err,
  output logic             eng_rst,
  output logic             eng_step,
  output logic [CMD_W-1:0] eng_cmd,
  input  logic             eng_isNotEnd,
  input  logic             eng_userWins,
  output logic [3:0]       game_idx,
  output logic [3:0]       user_score,
  output logic [3:0]       cpu_score,
  output logic             busy,
  output logic             timeout_pulse,
  output logic             match_done,
  output logic             user_match_win
);

  localparam logic [3:0] WIN_TGT  = 4'(GAMES / 2 + 1);
  localparam logic [3:0] LAST_G   = 4'(GAMES - 1);
  localparam logic [3:0] RST_LAST = 4'(ENG_RST_CYCLES - 1);

  ctrl_state_t state, nxt;

  logic [3:0] rst_cnt;
  logic       user_win;
  logic       hs, legal, expire;
  logic       tmr_clr, take, bad, to_fire, finish;
  logic [3:0] u_nxt, c_nxt;
  logic       restart;

  assign hs      = (state == WAIT_MOVE) && mv_valid;
  assign legal   = (mv_cmd <= FOURTH);
  assign restart = start && ((state == IDLE) || (state == DONE));

  sanmoku_move_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (tmr_clr),
    .en    (state == WAIT_MOVE),
    .expire(expire)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt     = state;
    tmr_clr = 1'b1;
    take    = 1'b0;
    bad     = 1'b0;
    to_fire = 1'b0;
    finish  = 1'b0;
    u_nxt   = user_score;
    c_nxt   = cpu_score;
    unique case (state)
      IDLE:  if (start) nxt = ERST;
      ERST:  if (rst_cnt == RST_LAST) nxt = WAIT_MOVE;
      WAIT_MOVE: begin
        tmr_clr = hs;
        // a consumed move always beats a same-cycle expiry
        if (hs && legal) begin
          take = 1'b1;
          nxt  = STEP;
        end else if (hs) begin
          bad = 1'b1;
        end else if (expire) begin
          to_fire = 1'b1;
          nxt     = STEP;
        end
      end
      STEP:  nxt = CHECK;
      CHECK: nxt = eng_isNotEnd ? WAIT_MOVE : SCORE;
      SCORE: begin
        if (user_win) u_nxt = sat_inc(user_score);
        else          c_nxt = sat_inc(cpu_score);
        finish = ((user_win ? u_nxt : c_nxt) == WIN_TGT)
               || (game_idx == LAST_G);
        nxt = finish ? DONE : ERST;
      end
      DONE:  if (start) nxt = ERST;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_cnt    <= '0;
      mv_err     <= 1'b0;
      eng_cmd    <= '0;
      user_win   <= 1'b0;
      user_score <= '0;
      cpu_score  <= '0;
      game_idx   <= '0;
    end else begin
      rst_cnt <= (state == ERST) ? rst_cnt + 4'd1 : 4'd0;
      mv_err  <= bad;
      if (take)         eng_cmd <= mv_cmd;
      else if (to_fire) eng_cmd <= CMD_W'(DEFAULT_CMD);
      if (state == CHECK) user_win <= eng_userWins;
      if (restart) begin
        user_score <= '0;
        cpu_score  <= '0;
        game_idx   <= '0;
      end else if (state == SCORE) begin
        user_score <= u_nxt;
        cpu_score  <= c_nxt;
        if (!finish) game_idx <= game_idx + 4'd1;
      end
    end
  end

  assign mv_ready       = (state == WAIT_MOVE);
  assign eng_rst        = (state == IDLE) || (state == ERST);
  assign eng_step       = (state == STEP);
  assign busy           = (state != IDLE) && (state != DONE);
  assign match_done     = (state == DONE);
  assign user_match_win = match_done && (user_score > cpu_score);
  assign timeout_pulse  = to_fire;

endmodule

// File: tb/tb_sanmoku_match_ctrl.sv
// Scoreboard bench for sanmoku_match_ctrl.
// Directed match scenarios against a small engine model.
module tb_sanmoku_match_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       start = 1'b0;
  logic       mv_valid = 1'b0;
  logic [3:0] mv_cmd = 4'd0;
  logic       mv_ready, mv_err, eng_rst, eng_step;
  logic [3:0] eng_cmd, game_idx, user_score, cpu_score;
  logic       eng_isNotEnd, eng_userWins;
  logic       busy, timeout_pulse, match_done, user_match_win;

  sanmoku_match_ctrl dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .start         (start),
    .mv_valid      (mv_valid),
    .mv_cmd        (mv_cmd),
    .mv_ready      (mv_ready),
    .mv_err        (mv_err),
    .eng_rst       (eng_rst),
    .eng_step      (eng_step),
    .eng_cmd       (eng_cmd),
    .eng_isNotEnd  (eng_isNotEnd),
    .eng_userWins  (eng_userWins),
    .game_idx      (game_idx),
    .user_score    (user_score),
    .cpu_score     (cpu_score),
    .busy          (busy),
    .timeout_pulse (timeout_pulse),
    .match_done    (match_done),
    .user_match_win(user_match_win)
  );

  always #5 CLK = ~CLK;

  // engine model: game ends after end_at steps, result = win
  int   gsteps = 0;
  int   end_at = 15;
  logic win = 1'b0;
  assign eng_isNotEnd = (gsteps < end_at);
  assign eng_userWins = win;
  always @(posedge CLK) begin
    if (eng_rst)       gsteps <= 0;
    else if (eng_step) gsteps <= gsteps + 1;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int n_steps = 0;
  int n_erst = 0;

  typedef enum logic [1:0] {EV_STEP, EV_ERR, EV_TO} ev_k;
  typedef struct packed {
    ev_k        k;
    logic [3:0] v;
  } ev_t;
  ev_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pop_cmp(input ev_k k, input logic [3:0] v);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d val %0d, none expected",
               k, v);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.v != v) begin
        n_fail++;
        $display("FAIL event: got kind %0d val %0d expected kind %0d val %0d",
                 k, v, e.k, e.v);
      end
    end
  endtask

  task automatic push(input ev_k k, input logic [3:0] v);
    exp_q.push_back('{k: k, v: v});
  endtask

  always @(negedge CLK) begin
    if (RST_N) begin
      if (timeout_pulse) pop_cmp(EV_TO, 4'd0);
      if (mv_err)        pop_cmp(EV_ERR, eng_cmd);
      if (eng_step) begin
        n_steps++;
        pop_cmp(EV_STEP, eng_cmd);
      end
      if (eng_rst && busy) n_erst++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!mv_ready && n < 3000);
    #1 chk("ready_wait", mv_ready, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!match_done && n < 3000);
    #1 chk("done_wait", match_done, 1);
  endtask

  task automatic send(input logic [3:0] c);
    wait_ready();
    mv_valid = 1'b1;
    mv_cmd   = c;
    @(negedge CLK);
    mv_valid = 1'b0;
  endtask

  initial begin
    int t0;
    int n;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_eng_rst", eng_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", mv_ready, 0);
    chk("rst_cmd", eng_cmd, 0);
    chk("rst_done", match_done, 0);
    @(negedge CLK) RST_N = 1'b1;

    // async reset from WAIT_MOVE
    pulse_start();
    wait_ready();
    #2 RST_N = 1'b0;
    #1;
    chk("arst_eng_rst", eng_rst, 1);
    chk("arst_busy", busy, 0);
    chk("arst_ready", mv_ready, 0);
    chk("arst_scores", {user_score, cpu_score, game_idx}, 0);
    @(negedge CLK) RST_N = 1'b1;

    // game 0: four moves, engine wins on the 4th step
    n_erst  = 0;
    n_steps = 0;
    end_at  = 4;
    win     = 1'b0;
    push(EV_STEP, FIRST_C(0));
    push(EV_STEP, 4'd2);
    push(EV_STEP, 4'd1);
    push(EV_STEP, 4'd1);
    pulse_start();
    send(4'd0);
    send(4'd2);
    send(4'd1);
    send(4'd1);
    wait_ready();
    chk("g0_cpu", cpu_score, 1);
    chk("g0_user", user_score, 0);
    chk("g0_idx", game_idx, 1);
    chk("g0_steps", n_steps, 4);
    chk("g0_erst", n_erst, 4);

    // game 1: timeout, illegal code, move at expiry
    end_at = 2;
    win    = 1'b1;
    t0     = cyc;
    push(EV_TO, 4'd0);
    push(EV_STEP, 4'd0);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!timeout_pulse && n < 2000);
    #1;
    chk("to_seen", timeout_pulse, 1);
    chk("to_delay", cyc - t0, 999);
    @(negedge CLK) #1;
    chk("to_step", eng_step, 1);
    chk("to_cmd", eng_cmd, 0);

    push(EV_ERR, 4'd0);
    send(4'd7);
    push(EV_STEP, 4'd3);
    repeat (999) @(negedge CLK);
    mv_valid = 1'b1;
    mv_cmd   = 4'd3;
    #1 chk("race_no_to", timeout_pulse, 0);
    @(negedge CLK) mv_valid = 1'b0;
    #1;
    chk("race_step", eng_step, 1);
    chk("race_cmd", eng_cmd, 3);

    // game 2: player win reaches target
    wait_ready();
    chk("g1_user", user_score, 1);
    chk("g1_cpu", cpu_score, 1);
    chk("g1_idx", game_idx, 2);
    end_at = 1;
    win    = 1'b1;
    push(EV_STEP, 4'd3);
    send(4'd3);
    wait_done();
    chk("m1_user", user_score, 2);
    chk("m1_cpu", cpu_score, 1);
    chk("m1_win", user_match_win, 1);
    chk("m1_busy", busy, 0);

    // second match: restart from DONE, 2-0 sweep
    pulse_start();
    #1;
    chk("m2_clr", {user_score, cpu_score, game_idx}, 0);
    chk("m2_busy", busy, 1);
    chk("m2_done", match_done, 0);
    push(EV_STEP, 4'd1);
    send(4'd1);
    wait_ready();
    chk("m2g0_user", user_score, 1);
    chk("m2g0_idx", game_idx, 1);
    pulse_start();
    #1;
    chk("busy_start_ready", mv_ready, 1);
    chk("busy_start_idx", game_idx, 1);
    chk("busy_start_user", user_score, 1);
    push(EV_STEP, 4'd2);
    send(4'd2);
    wait_done();
    chk("m2_user", user_score, 2);
    chk("m2_cpu", cpu_score, 0);
    chk("m2_idx", game_idx, 1);
    chk("m2_win", user_match_win, 1);
    chk("q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  function automatic logic [3:0] FIRST_C(input int i);
    return 4'(i);
  endfunction

endmodule

// File: doc/sanmoku_match_ctrl.md
Name: sanmoku_match_ctrl

Overview:
Match-level sequencer wrapped around the sanmoku game engine.
- Resets the engine between games and accepts player moves over a valid/ready handshake.
- Steps the engine exactly once per accepted move, and substitutes a default move when the player times out.
- Scores a best-of-GAMES match and reports the winner.
- Sits between the board/user-input front end and the engine's cmd/step/status interface.

Parameters:
GAMES, 3, games per match (odd, 1..15); win target WIN_TGT = GAMES/2+1
TIMEOUT, 1000, cycles in WAIT_MOVE before the default move is injected (>=2)
DEFAULT_CMD, 0, move code injected on timeout (must be 0..3)
ENG_RST_CYCLES, 2, cycles eng_rst is held high at the start of each game (>=1)

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
start  in  1  pulse; begins a match from IDLE or DONE, ignored otherwise
mv_valid  in  1  player move present
mv_cmd  in  4  player move code; legal codes 0..3 (FIRST=0, SECOND=2, THIRD=1, FOURTH=3)
mv_ready  out  1  controller can accept a move
mv_err  out  1  one-cycle pulse: illegal code consumed
eng_rst  out  1  active-high synchronous reset to the engine
eng_step  out  1  one-cycle engine advance strobe
eng_cmd  out  4  move applied on eng_step; held stable otherwise
eng_isNotEnd  in  1  engine status, valid one cycle after eng_step
eng_userWins  in  1  engine result, meaningful when eng_isNotEnd=0
game_idx  out  4  current game number, 0-based
user_score  out  4  games won by the player
cpu_score  out  4  games won by the engine
busy  out  1  high in every state except IDLE and DONE
timeout_pulse  out  1  one-cycle pulse when the default move is injected
match_done  out  1  high in DONE
user_match_win  out  1  valid while match_done; 1 = player reached WIN_TGT

Behaviour:
- Reset values: all outputs 0 except eng_rst=1; state IDLE; all counters 0; eng_cmd=0.
- An async reset asserted mid-operation returns to the IDLE reset values immediately. No partial score is retained.

States and transitions:
- IDLE: start -> ERST. Clears user_score, cpu_score and game_idx.
- ERST: eng_rst=1 for ENG_RST_CYCLES cycles, counted by rst_cnt -> WAIT_MOVE.
- WAIT_MOVE:
  - mv_ready=1.
  - On mv_valid && mv_ready with mv_cmd<=3: latch eng_cmd=mv_cmd -> STEP.
  - On mv_valid && mv_ready with mv_cmd>3: consume the move, pulse mv_err next cycle, stay, restart the timer.
  - Timer counts cycles spent in WAIT_MOVE. When it reaches TIMEOUT-1 with no handshake: eng_cmd=DEFAULT_CMD, pulse timeout_pulse -> STEP.
  - A handshake and expiry in the same cycle: the player move wins, and timeout_pulse does not fire.
- STEP: eng_step=1 for exactly one cycle -> CHECK. mv_ready=0.
- CHECK: sample the engine status.
  - eng_isNotEnd=1 -> WAIT_MOVE.
  - Otherwise latch eng_userWins -> SCORE.
- SCORE: increment user_score or cpu_score.
  - If the updated score == WIN_TGT, or game_idx == GAMES-1 -> DONE.
  - Else game_idx++ -> ERST.
- DONE: match_done=1. user_match_win = (user_score > cpu_score). Outputs are held. start -> ERST with scores cleared.

Other rules:
- start while busy is ignored.
- mv_valid outside WAIT_MOVE is not consumed.
- Counters are 4-bit; scores saturate at 15, which is unreachable for legal GAMES.
- Move-to-step latency is 1 cycle (handshake edge -> eng_step high).
- Step-to-decision latency is 1 cycle.

Decomposition:
- sanmoku_pkg holds:
  - move code constants FIRST/SECOND/THIRD/FOURTH
  - CMD_W=4
  - ctrl_state_t enum {IDLE, ERST, WAIT_MOVE, STEP, CHECK, SCORE, DONE}
- One sub-module, sanmoku_move_timer:
  - Load/clear counter with an expire output.
  - Cleared on entry to WAIT_MOVE and on every consumed move.
- Scoring and the FSM stay in the top module.

Test Plan:
- Reset while in WAIT_MOVE -> eng_rst=1, busy=0, all scores 0, state IDLE within 0 cycles.
- start; moves 0,2,1,1 with the engine model ending on the 4th step, userWins=0 -> cpu_score=1, game_idx=1, eng_rst high for 2 cycles, eng_step exactly 4 pulses.
- No mv_valid in WAIT_MOVE -> timeout_pulse after 1000 cycles, eng_cmd=0, eng_step the next cycle.
- mv_cmd=7 -> mv_err pulse, no eng_step, timer restarts. Then mv_cmd=3 -> eng_cmd=3 stepped.
- mv_valid in the same cycle as timer expiry -> player code used, timeout_pulse stays 0.
- GAMES=3, player wins games 0 and 1 -> DONE after 2 games, user_score=2, user_match_win=1; start during the match is ignored, start in DONE restarts with scores 0.
